// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU beside the EX stage.
// One quotient bit per cycle; stalls the pipeline and pulses ready with LO/HI results.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stallreq,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic               ready_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;

    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   dvd_d;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg_f(v) : v;
    endfunction

    // One restoring iteration: shift {rem, dvd} left, trial-subtract, shift in the quotient bit
    always_comb begin
        shift_s = {rem_q, dvd_q[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_q};
        rem_d   = shift_s[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            rem_d = diff_s[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shift_s[WIDTH-1:0];
        end
        quo_fix_s = sign_q_q ? neg_f(dvd_d) : dvd_d;
        rem_fix_s = sign_r_q ? neg_f(rem_d) : rem_d;
    end

    // Sequencer and datapath registers; results only change on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !annul) begin
                        cnt_q    <= {CNT_W{1'b0}};
                        rem_q    <= {WIDTH{1'b0}};
                        dvs_q    <= abs_f(divisor, signed_div);
                        sign_q_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r_q <= signed_div & dividend[WIDTH-1];
                        // Divide-by-zero reports the raw dividend, so keep it unmodified
                        if (divisor == {WIDTH{1'b0}}) begin
                            dvd_q   <= dividend;
                            state_q <= ZERO;
                        end else begin
                            dvd_q   <= abs_f(dividend, signed_div);
                            state_q <= BUSY;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_q == LAST_CNT) begin
                            quotient_q  <= quo_fix_s;
                            remainder_q <= rem_fix_s;
                            ready_q     <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                ZERO: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        quotient_q  <= ALL_ONES;
                        remainder_q <= dvd_q;
                        ready_q     <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall drops with annul or reset in the same cycle, and is released while DONE
    assign stallreq  = rst & ~annul &
                       ((state_q == IDLE && start) || state_q == BUSY || state_q == ZERO);
    assign ready     = ready_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random divides
// against an arithmetic reference model (64-bit signed/unsigned division).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        annul = 1'b0;
    logic        stallreq;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int vectors = 0;
    int miscompares = 0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stallreq   (stallreq),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Caller is just past a rising edge with the DUT idle; this cycle is cycle 0.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit keep_start);
        logic [31:0] eq, er, oq, orr;
        int lat, ready_cyc, stall_n, pulses;
        model(sgn, a, b, eq, er);
        lat = (b == 32'd0) ? 2 : 33;
        start = 1'b1; signed_div = sgn; dividend = a; divisor = b;
        ready_cyc = -1; stall_n = 0; pulses = 0; oq = 32'd0; orr = 32'd0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (stallreq) stall_n++;
            if (ready) begin
                pulses++;
                if (ready_cyc < 0) ready_cyc = c;
            end
            if (c == lat) begin oq = quotient; orr = remainder; end
            @(posedge clk); #1;
            if (c == 0) begin dividend = $urandom; divisor = $urandom; end
        end
        if (!keep_start) start = 1'b0;
        chk({tag, "_ready_cycle"}, 64'(ready_cyc), 64'(lat));
        chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(lat));
        chk({tag, "_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_q"}, 64'(oq), 64'(eq));
        chk({tag, "_r"}, 64'(orr), 64'(er));
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        int          pulses, stall_n;

        // Reset state
        #12;
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        chk("divu_100_7_const_q", 64'(quotient), 64'd14);
        chk("divu_100_7_const_r", 64'(remainder), 64'd2);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7_2_const_q", 64'(quotient), 64'hFFFF_FFFD);
        chk("div_m7_2_const_r", 64'(remainder), 64'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("div_7_m2_const_q", 64'(quotient), 64'hFFFF_FFFD);
        chk("div_7_m2_const_r", 64'(remainder), 64'd1);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
        chk("divu_5_0_const_q", 64'(quotient), 64'hFFFF_FFFF);
        chk("divu_5_0_const_r", 64'(remainder), 64'd5);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_min_m1_const_q", 64'(quotient), 64'h8000_0000);
        chk("div_min_m1_const_r", 64'(remainder), 64'd0);
        run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b0);

        // Back-to-back: start stays high so the second divide is accepted right after DONE
        @(posedge clk); #1;
        run_div("b2b_first", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        run_div("b2b_second", 1'b0, 32'd9, 32'd3, 1'b0);
        chk("b2b_second_const_q", 64'(quotient), 64'd3);

        // Annul at cycle 10 of a divide
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        pulses = 0; stall_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (stallreq) stall_n++;
        end
        chk("annul_no_ready", 64'(pulses), 64'd0);
        chk("annul_idle_stall", 64'(stall_n), 64'd0);
        chk("annul_keep_q", 64'(quotient), 64'd3);
        chk("annul_keep_r", 64'(remainder), 64'd0);
        @(posedge clk); #1;
        run_div("divu_20_6", 1'b0, 32'd20, 32'd6, 1'b0);

        // Asynchronous reset mid-BUSY, between clock edges
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; dividend = 32'd77; divisor = 32'd5;
        repeat (15) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_q", 64'(quotient), 64'd0);
        chk("arst_r", 64'(remainder), 64'd0);
        chk("arst_stall", 64'(stallreq), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        start = 1'b0;
        #3 rst = 1'b1;
        pulses = 0; stall_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (stallreq) stall_n++;
        end
        chk("arst_idle_ready", 64'(pulses), 64'd0);
        chk("arst_idle_stall", 64'(stall_n), 64'd0);
        @(posedge clk); #1;
        run_div("divu_8_8", 1'b0, 32'd8, 32'd8, 1'b0);

        // Random divides against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 255);
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            @(posedge clk); #1;
            run_div("rand", rs, ra, rb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
